// File: rtl/ram_loader_if.sv
// rtl/ram_loader_if.sv - program-stream and RAM bus bundle between loader, source and RAM
//
// Signals:
//   in_data/in_valid/in_ready  byte stream from the program source into the loader
//   address                    one-hot cell select, all-zero when idle
//   data                       write data to RAM
//   ram_in / ram_out           RAM load strobe / RAM output enable
//   ram_q                      RAM gated output, combinational from the selected cell
// Modports: master = loader side, slave = source + RAM side.
interface ram_loader_if #(
    parameter int RAM_SIZE = 16
);
    logic [7:0]          in_data;
    logic                in_valid;
    logic                in_ready;
    logic [RAM_SIZE-1:0] address;
    logic [7:0]          data;
    logic                ram_in;
    logic                ram_out;
    logic [7:0]          ram_q;

    modport master (
        input  in_data, in_valid, ram_q,
        output in_ready, address, data, ram_in, ram_out
    );

    modport slave (
        output in_data, in_valid, ram_q,
        input  in_ready, address, data, ram_in, ram_out
    );
endinterface

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - loads RAM_SIZE bytes into the one-hot RAM, reads them back and checks sums
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     begin a load, sampled only in IDLE
//   bus       ram_loader_if.master: byte stream in, RAM address/data/strobes out, ram_q in
//   busy      high while a load is in progress (WAIT..CHECK)
//   done      one-cycle pulse at end of load
//   error     read-back sum differed from write sum; held until next accepted start
//   checksum  write-phase sum mod 256, held after done
module ram_loader #(
    parameter int RAM_SIZE = 16,
    parameter int ADDR_W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    ram_loader_if.master bus,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [7:0]   checksum
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [ADDR_W-1:0]   LAST = ADDR_W'(RAM_SIZE - 1);
    localparam logic [RAM_SIZE-1:0] ONE  = RAM_SIZE'(1);

    logic [2:0]          state_q, state_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic [7:0]          hold_q, hold_d;
    logic [7:0]          wsum_q, wsum_d;
    logic [7:0]          rsum_q, rsum_d;
    logic                error_q, error_d;
    logic [7:0]          checksum_q, checksum_d;
    logic [RAM_SIZE-1:0] address_q;
    logic                ram_in_q, ram_out_q, busy_q, done_q;

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        hold_d     = hold_q;
        wsum_d     = wsum_q;
        rsum_d     = rsum_q;
        error_d    = error_q;
        checksum_d = checksum_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    index_d = '0;
                    wsum_d  = '0;
                    rsum_d  = '0;
                    error_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.in_valid) begin
                    hold_d  = bus.in_data;
                    wsum_d  = wsum_q + bus.in_data;
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                if (index_q == LAST) begin
                    index_d = '0;
                    state_d = S_READ;
                end else begin
                    index_d = index_q + ADDR_W'(1);
                    state_d = S_WAIT;
                end
            end
            S_READ: begin
                // address_q already selects index_q, so ram_q is this cell's value
                rsum_d = rsum_q + bus.ram_q;
                if (index_q == LAST) begin
                    index_d = '0;
                    state_d = S_CHECK;
                end else begin
                    index_d = index_q + ADDR_W'(1);
                end
            end
            S_CHECK: begin
                error_d    = (rsum_q != wsum_q);
                checksum_d = wsum_q;
                state_d    = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they line up with
    // the state they belong to rather than lagging it by a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            hold_q     <= '0;
            wsum_q     <= '0;
            rsum_q     <= '0;
            error_q    <= 1'b0;
            checksum_q <= '0;
            address_q  <= '0;
            ram_in_q   <= 1'b0;
            ram_out_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            hold_q     <= hold_d;
            wsum_q     <= wsum_d;
            rsum_q     <= rsum_d;
            error_q    <= error_d;
            checksum_q <= checksum_d;
            address_q  <= (state_d == S_STROBE || state_d == S_READ) ? (ONE << index_d) : '0;
            ram_in_q   <= (state_d == S_STROBE);
            ram_out_q  <= (state_d == S_READ);
            busy_q     <= (state_d == S_WAIT) || (state_d == S_STROBE) ||
                          (state_d == S_READ) || (state_d == S_CHECK);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign bus.in_ready = (state_q == S_WAIT);
    assign bus.address  = address_q;
    assign bus.data     = hold_q;
    assign bus.ram_in   = ram_in_q;
    assign bus.ram_out  = ram_out_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign checksum     = checksum_q;
endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - self-checking bench for ram_loader with a behavioural RAM and stream source
module tb_ram_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, error;
    logic [7:0] checksum;
    logic       corrupt;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem   [16];
    logic [7:0] bytes [16];
    logic [7:0] acc_mem [1024];
    int hs_cnt = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    ram_loader_if #(.RAM_SIZE(16)) bus ();

    ram_loader #(.RAM_SIZE(16), .ADDR_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int oh_idx(input logic [15:0] a);
        for (int i = 0; i < 16; i++) if (a[i]) return i;
        return 0;
    endfunction

    // RAM model: gated output, optional bit flip on cell 3 read-back
    always_comb begin
        bus.ram_q = 8'h00;
        if (bus.ram_out) begin
            bus.ram_q = mem[oh_idx(bus.address)];
            if (corrupt && bus.address == 16'h0008) bus.ram_q = mem[3] ^ 8'h04;
        end
    end

    // RAM cell load and stream handshake capture on the active edge
    always @(posedge clk) begin
        if (rst) begin
            hs_cnt = 0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                acc_mem[hs_cnt % 1024] = bus.in_data;
                hs_cnt++;
            end
            if (bus.ram_in) mem[oh_idx(bus.address)] = bus.data;
        end
    end

    // Bus protocol scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            wr_cnt = 0;
            rd_cnt = 0;
        end else begin
            if (bus.ram_in || bus.ram_out)
                chk("in_out_excl", {31'd0, bus.ram_in & bus.ram_out}, 0);
            if (bus.in_ready)
                chk("in_ready_state", {28'd0, bus.ram_in, bus.ram_out, done, !busy}, 0);
            if (bus.ram_in) begin
                chk("wr_handshake", {31'd0, wr_cnt < hs_cnt}, 1);
                chk("wr_addr", {16'd0, bus.address}, 32'd1 << (wr_cnt % 16));
                chk("wr_data", {24'd0, bus.data}, {24'd0, acc_mem[wr_cnt % 1024]});
                wr_cnt++;
            end
            if (bus.ram_out) begin
                chk("rd_addr", {16'd0, bus.address}, 32'd1 << (rd_cnt % 16));
                rd_cnt++;
            end
        end
    end

    // mode 0: in_valid held high, 1: valid pattern 1,0,0,1, 2: random gaps
    task automatic do_load(input int mode, input bit poke, input int abort_cell,
                           output int done_cyc, output bit aborted);
        int c, ptr, gap;
        bit v;
        logic [3:0] pat;
        pat = 4'b1001;
        ptr = 0; gap = 0; c = 0;
        done_cyc = -1; aborted = 1'b0;
        bus.in_valid = 1'b0;
        start = 1'b1;
        while (c < 400 && done_cyc < 0 && !aborted) begin
            @(negedge clk);
            c++;
            start = (poke && c > 2 && c < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (c == 1) chk("err_clr_on_start", {31'd0, error}, 0);
            if (abort_cell >= 0 && bus.ram_out && bus.address == (16'd1 << abort_cell)) begin
                rst = 1'b1;
                aborted = 1'b1;
            end else if (done) begin
                done_cyc = c;
                chk("busy_at_done", {31'd0, busy}, 0);
            end else begin
                case (mode)
                    0:       v = 1'b1;
                    1:       v = pat[c % 4];
                    default: begin
                        v = (gap == 0);
                        if (gap > 0) gap--;
                    end
                endcase
                if (ptr < 16 && v) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = bytes[ptr];
                    if (bus.in_ready) begin
                        ptr++;
                        gap = $urandom_range(0, 3);
                    end
                end else if (mode == 0) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = 8'($urandom);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0;
        start = 1'b0;
        if (done_cyc < 0 && !aborted) chk("done_timeout", 0, 1);
    endtask

    task automatic check_load(input string tag, input int done_cyc, input int exp_cyc,
                              input bit corrupt_en);
        logic [7:0] ws, rs;
        int mism;
        ws = 0; rs = 0; mism = 0;
        for (int i = 0; i < 16; i++) begin
            ws = ws + bytes[i];
            rs = rs + ((corrupt_en && i == 3) ? (bytes[i] ^ 8'h04) : bytes[i]);
            if (mem[i] !== bytes[i]) mism++;
        end
        chk({tag, "_checksum"}, {24'd0, checksum}, {24'd0, ws});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, rs != ws});
        chk({tag, "_mem"}, mism, 0);
        if (exp_cyc > 0) chk({tag, "_done_cycle"}, done_cyc, exp_cyc);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, done}, 0);
    endtask

    initial begin
        int  dc, dn;
        bit  ab;
        rst = 1'b1; start = 1'b0; corrupt = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_address",  {16'd0, bus.address}, 0);
        chk("rst_data",     {24'd0, bus.data}, 0);
        chk("rst_ram_in",   {31'd0, bus.ram_in}, 0);
        chk("rst_ram_out",  {31'd0, bus.ram_out}, 0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 0);
        chk("rst_busy",     {31'd0, busy}, 0);
        chk("rst_done",     {31'd0, done}, 0);
        chk("rst_error",    {31'd0, error}, 0);
        chk("rst_checksum", {24'd0, checksum}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) bytes[i] = 8'(i + 1);
        do_load(0, 1'b0, -1, dc, ab);
        check_load("ramp", dc, 50, 1'b0);
        chk("ramp_sum_const", {24'd0, checksum}, 32'h88);

        for (int i = 0; i < 16; i++) bytes[i] = 8'hFF;
        do_load(0, 1'b0, -1, dc, ab);
        check_load("ff", dc, 50, 1'b0);
        chk("ff_sum_wrap", {24'd0, checksum}, 32'hF0);
        chk("ff_cell7", {24'd0, mem[7]}, 32'hFF);

        for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
        do_load(1, 1'b0, -1, dc, ab);
        check_load("pat1001", dc, 0, 1'b0);

        for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
        do_load(2, 1'b0, -1, dc, ab);
        check_load("gaps", dc, 0, 1'b0);

        corrupt = 1'b1;
        for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
        do_load(0, 1'b0, -1, dc, ab);
        check_load("corrupt", dc, 50, 1'b1);
        repeat (5) @(negedge clk);
        chk("corrupt_err_hold", {31'd0, error}, 1);
        corrupt = 1'b0;

        for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
        do_load(0, 1'b0, 5, dc, ab);
        chk("abort_reached", {31'd0, ab}, 1);
        @(negedge clk);
        chk("abort_address", {16'd0, bus.address}, 0);
        chk("abort_ram_out", {31'd0, bus.ram_out}, 0);
        chk("abort_busy",    {31'd0, busy}, 0);
        chk("abort_done",    {31'd0, done}, 0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_no_done", dn, 0);
        for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
        do_load(2, 1'b0, -1, dc, ab);
        check_load("after_abort", dc, 0, 1'b0);

        for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
        do_load(0, 1'b1, -1, dc, ab);
        check_load("poke_start", dc, 50, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
